// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter and access sequencer.
// Port 0 is the CPU load/store path and port 1 is the program/debug loader.
// The block grants the single memory port to one requester at a time, using
// round-robin on conflict. Each access runs over LAT memory cycles and is
// followed by a one-cycle done pulse that carries the load data.
module dmem_arbiter #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          r0_req_i,
  input  logic          r0_we_i,
  input  logic [AW-1:0] r0_addr_i,
  input  logic [DW-1:0] r0_wdata_i,
  input  logic [1:0]    r0_type_i,
  input  logic          r0_sign_i,
  output logic          r0_gnt_o,
  output logic          r0_done_o,
  output logic [DW-1:0] r0_rdata_o,

  input  logic          r1_req_i,
  input  logic          r1_we_i,
  input  logic [AW-1:0] r1_addr_i,
  input  logic [DW-1:0] r1_wdata_i,
  input  logic [1:0]    r1_type_i,
  input  logic          r1_sign_i,
  output logic          r1_gnt_o,
  output logic          r1_done_o,
  output logic [DW-1:0] r1_rdata_o,

  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [1:0]    mem_type_o,
  output logic          mem_sign_o,
  input  logic [DW-1:0] mem_rdata_i,

  output logic          cpu_stall_o,
  output logic          busy_o
);

  // Counter preload: LAT-1 gives exactly LAT cycles in ACCESS.
  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [2:0]      cnt_q;
  logic            win_q;
  logic            last_q;
  logic [DW-1:0]   rdata_q;

  logic            hold_we_q;
  logic [AW-1:0]   hold_addr_q;
  logic [DW-1:0]   hold_wdata_q;
  logic [1:0]      hold_type_q;
  logic            hold_sign_q;

  logic            any_req;
  logic            pick;
  logic            accept;
  logic            in_access;
  logic            in_done;

  // Winner selection: a lone requester wins; on conflict the port that was
  // not served last wins.
  always_comb begin
    any_req = r0_req_i | r1_req_i;
    if (r0_req_i && r1_req_i) begin
      pick = ~last_q;
    end else begin
      pick = r1_req_i;
    end
  end

  // A request is accepted only from IDLE; rst gating keeps the grant low
  // while reset is asserted.
  always_comb begin
    accept    = rst && (state_q == IDLE) && any_req;
    in_access = (state_q == ACCESS);
    in_done   = (state_q == DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction capture, latency counter, read data and last-served pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      win_q        <= 1'b0;
      last_q       <= 1'b1;
      rdata_q      <= '0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_type_q  <= '0;
      hold_sign_q  <= 1'b0;
    end else begin
      if (accept) begin
        win_q <= pick;
        cnt_q <= LAT_M1;
        if (pick) begin
          hold_we_q    <= r1_we_i;
          hold_addr_q  <= r1_addr_i;
          hold_wdata_q <= r1_wdata_i;
          hold_type_q  <= r1_type_i;
          hold_sign_q  <= r1_sign_i;
        end else begin
          hold_we_q    <= r0_we_i;
          hold_addr_q  <= r0_addr_i;
          hold_wdata_q <= r0_wdata_i;
          hold_type_q  <= r0_type_i;
          hold_sign_q  <= r0_sign_i;
        end
      end else if (in_access) begin
        if (cnt_q == 3'd0) begin
          rdata_q <= hold_we_q ? '0 : mem_rdata_i;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end else if (in_done) begin
        last_q <= win_q;
      end
    end
  end

  // Memory port: driven only in ACCESS; the write strobe is limited to the
  // first ACCESS cycle, recognised by the counter still holding its preload.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_type_o  = '0;
    mem_sign_o  = 1'b0;
    if (in_access) begin
      mem_we_o    = hold_we_q && (cnt_q == LAT_M1);
      mem_addr_o  = hold_addr_q;
      mem_wdata_o = hold_wdata_q;
      mem_type_o  = hold_type_q;
      mem_sign_o  = hold_sign_q;
    end
  end

  // Requester handshake outputs, CPU stall and busy flag.
  always_comb begin
    r0_gnt_o    = accept && !pick;
    r1_gnt_o    = accept && pick;
    r0_done_o   = in_done && !win_q;
    r1_done_o   = in_done && win_q;
    r0_rdata_o  = r0_done_o ? rdata_q : '0;
    r1_rdata_o  = r1_done_o ? rdata_q : '0;
    cpu_stall_o = r0_req_i && !r0_done_o;
    busy_o      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-schedule model.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0_req_i, r0_we_i, r0_sign_i;
  logic [31:0] r0_addr_i, r0_wdata_i;
  logic [1:0]  r0_type_i;
  logic        r1_req_i, r1_we_i, r1_sign_i;
  logic [31:0] r1_addr_i, r1_wdata_i;
  logic [1:0]  r1_type_i;
  logic        r0_gnt_o, r0_done_o, r1_gnt_o, r1_done_o;
  logic [31:0] r0_rdata_o, r1_rdata_o;
  logic        mem_we_o, mem_sign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]  mem_type_o;
  logic        cpu_stall_o, busy_o;

  dmem_arbiter #(.DW(32), .AW(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_addr_i(r0_addr_i),
    .r0_wdata_i(r0_wdata_i), .r0_type_i(r0_type_i), .r0_sign_i(r0_sign_i),
    .r0_gnt_o(r0_gnt_o), .r0_done_o(r0_done_o), .r0_rdata_o(r0_rdata_o),
    .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_addr_i(r1_addr_i),
    .r1_wdata_i(r1_wdata_i), .r1_type_i(r1_type_i), .r1_sign_i(r1_sign_i),
    .r1_gnt_o(r1_gnt_o), .r1_done_o(r1_done_o), .r1_rdata_o(r1_rdata_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_type_o(mem_type_o), .mem_sign_o(mem_sign_o), .mem_rdata_i(mem_rdata_i),
    .cpu_stall_o(cpu_stall_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: one transaction at a time, described by its grant cycle; the
  // memory is busy from the cycle after grant up to and including done.
  int unsigned cyc = 0;
  int unsigned free_at = 0;
  int unsigned gcyc = 0;
  logic        last_m = 1'b1;
  logic        m_win = 1'b0;
  logic        m_we = 1'b0;
  logic        m_sign = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [1:0]  m_type = '0;
  logic [31:0] rd_exp = '0;

  logic [1:0]  g_seen = '0;
  logic [1:0]  d_seen = '0;
  logic [31:0] o_rd0 = '0;
  logic [31:0] o_rd1 = '0;
  int          we_cnt = 0;
  int          pst [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] typ, input logic sign);
    if (p == 0) begin
      r0_req_i = req; r0_we_i = we; r0_addr_i = addr; r0_wdata_i = wdata;
      r0_type_i = typ; r0_sign_i = sign;
    end else begin
      r1_req_i = req; r1_we_i = we; r1_addr_i = addr; r1_wdata_i = wdata;
      r1_type_i = typ; r1_sign_i = sign;
    end
  endtask

  task automatic rand_port(input int p, input logic req);
    set_port(p, req, 1'($urandom_range(0, 1)), $urandom, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // Evaluate the model for the current cycle, compare every output, then
  // advance to the next falling edge where new inputs are applied.
  task automatic cycle();
    logic [1:0]  eg, ed;
    logic [31:0] erd [2];
    logic        ewe, es, ebusy;
    logic [31:0] eaddr, ewd;
    logic [1:0]  et;
    int          ph;
    eg = '0; ed = '0; erd[0] = '0; erd[1] = '0;
    ewe = 1'b0; es = 1'b0; ebusy = 1'b0; eaddr = '0; ewd = '0; et = '0;
    #1;
    if (cyc < free_at) begin
      ebusy = 1'b1;
      ph = int'(cyc - gcyc);
      if (ph >= 1 && ph <= int'(LAT)) begin
        eaddr = m_addr; ewd = m_wdata; et = m_type; es = m_sign;
        ewe = m_we && (ph == 1);
      end
      if (ph == int'(LAT)) rd_exp = m_we ? 32'h0 : mem_rdata_i;
      if (ph == int'(LAT) + 1) begin
        ed[m_win] = 1'b1;
        erd[m_win] = rd_exp;
        last_m = m_win;
      end
    end else if (r0_req_i || r1_req_i) begin
      m_win = (r0_req_i && r1_req_i) ? ~last_m : r1_req_i;
      eg[m_win] = 1'b1;
      if (m_win) begin
        m_we = r1_we_i; m_addr = r1_addr_i; m_wdata = r1_wdata_i; m_type = r1_type_i; m_sign = r1_sign_i;
      end else begin
        m_we = r0_we_i; m_addr = r0_addr_i; m_wdata = r0_wdata_i; m_type = r0_type_i; m_sign = r0_sign_i;
      end
      gcyc = cyc;
      free_at = cyc + LAT + 2;
    end
    chk("r0_gnt", r0_gnt_o, eg[0]);
    chk("r1_gnt", r1_gnt_o, eg[1]);
    chk("r0_done", r0_done_o, ed[0]);
    chk("r1_done", r1_done_o, ed[1]);
    chk("r0_rdata", r0_rdata_o, erd[0]);
    chk("r1_rdata", r1_rdata_o, erd[1]);
    chk("mem_we", mem_we_o, ewe);
    chk("mem_addr", mem_addr_o, eaddr);
    chk("mem_wdata", mem_wdata_o, ewd);
    chk("mem_type", mem_type_o, et);
    chk("mem_sign", mem_sign_o, es);
    chk("cpu_stall", cpu_stall_o, r0_req_i && !ed[0]);
    chk("busy", busy_o, ebusy);
    g_seen = eg;
    d_seen = ed;
    if (r0_done_o) o_rd0 = r0_rdata_o;
    if (r1_done_o) o_rd1 = r1_rdata_o;
    if (mem_we_o) we_cnt++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int gk, dk, gk2, n;
    int order [4];
    int dn0, dn1;

    // Reset state: outputs low, stall follows r0 request.
    rst = 1'b0;
    mem_rdata_i = '0;
    set_port(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    set_port(1, 1'b1, 1'b1, 32'h44, 32'h55, 2'd1, 1'b1);
    #2;
    chk("rst_gnt0", r0_gnt_o, 1'b0);
    chk("rst_gnt1", r1_gnt_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_stall", cpu_stall_o, 1'b1);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single load.
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    mem_rdata_i = 32'hDEADBEEF;
    gk = -100; dk = -1;
    for (int i = 0; i < 10 && dk < 0; i++) begin
      cycle();
      if (g_seen[0] && gk < 0) gk = int'(cyc) - 1;
      if (d_seen[0]) begin dk = int'(cyc) - 1; r0_req_i = 1'b0; end
    end
    chk("load_latency", 32'(dk - gk), LAT + 1);
    chk("load_rdata", o_rd0, 32'hDEADBEEF);

    // Single store from the loader port.
    set_port(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0);
    we_cnt = 0; gk = -100; dk = -1; o_rd1 = 32'hFFFFFFFF;
    for (int i = 0; i < 10 && dk < 0; i++) begin
      mem_rdata_i = $urandom;
      cycle();
      if (g_seen[1] && gk < 0) gk = int'(cyc) - 1;
      if (d_seen[1]) begin dk = int'(cyc) - 1; r1_req_i = 1'b0; end
    end
    chk("store_we_pulses", 32'(we_cnt), 32'd1);
    chk("store_latency", 32'(dk - gk), LAT + 1);
    chk("store_rdata", o_rd1, 32'h0);

    // Conflict: both ports hold requests; grants must alternate from r0.
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1);
    set_port(1, 1'b1, 1'b0, 32'h200, 32'h0, 2'd1, 1'b0);
    n = 0; dn0 = 0; dn1 = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int i = 0; i < 40 && (dn0 + dn1) < 4; i++) begin
      mem_rdata_i = $urandom;
      cycle();
      if (g_seen != 2'b00 && n < 4) begin order[n] = g_seen[1] ? 1 : 0; n++; end
      if (d_seen[0]) dn0++;
      if (d_seen[1]) dn1++;
      if ((dn0 + dn1) == 4) begin r0_req_i = 1'b0; r1_req_i = 1'b0; end
    end
    for (int i = 0; i < 4; i++) chk("conflict_order", 32'(order[i]), 32'(i % 2));
    chk("conflict_done0", 32'(dn0), 32'd2);
    chk("conflict_done1", 32'(dn1), 32'd2);

    // Lone requester: back-to-back grants every LAT+2 cycles.
    set_port(1, 1'b1, 1'b0, 32'h300, 32'h0, 2'd0, 1'b0);
    gk = -1; n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      mem_rdata_i = $urandom;
      cycle();
      if (g_seen[1]) begin
        if (gk >= 0) chk("lone_interval", 32'(int'(cyc) - 1 - gk), LAT + 2);
        gk = int'(cyc) - 1;
        n++;
      end
    end
    // Let the final access finish, then release the request.
    dk = -1;
    for (int i = 0; i < 10 && dk < 0; i++) begin
      cycle();
      if (d_seen[1]) begin dk = 1; r1_req_i = 1'b0; end
    end
    chk("lone_grants", 32'(n), 32'd3);

    // Late request: r0 asks while r1 is in ACCESS.
    set_port(1, 1'b1, 1'b0, 32'h500, 32'h0, 2'd2, 1'b0);
    dk = -1; gk2 = -1;
    for (int i = 0; i < 20 && gk2 < 0; i++) begin
      mem_rdata_i = $urandom;
      cycle();
      if (g_seen[1]) set_port(0, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1);
      if (d_seen[1]) begin dk = int'(cyc) - 1; r1_req_i = 1'b0; end
      if (g_seen[0]) gk2 = int'(cyc) - 1;
    end
    chk("late_grant", 32'(gk2 - dk), 32'd1);
    dk = -1;
    for (int i = 0; i < 10 && dk < 0; i++) begin
      mem_rdata_i = $urandom;
      cycle();
      if (d_seen[0]) begin dk = 1; r0_req_i = 1'b0; end
    end
    chk("late_done", 32'(dk), 32'd1);

    // Reset during the first ACCESS cycle of a store.
    set_port(1, 1'b1, 1'b1, 32'h700, 32'hCAFEF00D, 2'd2, 1'b0);
    gk = -1;
    for (int i = 0; i < 5 && gk < 0; i++) begin
      cycle();
      if (g_seen[1]) gk = 1;
    end
    #1;
    chk("midrst_we_before", mem_we_o, 1'b1);
    r0_req_i = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_we", mem_we_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done1", r1_done_o, 1'b0);
    chk("midrst_gnt0", r0_gnt_o, 1'b0);
    chk("midrst_stall", cpu_stall_o, 1'b1);
    @(posedge clk);
    cyc++;
    #1;
    chk("midrst_done_hold", r1_done_o, 1'b0);
    @(negedge clk);
    r0_req_i = 1'b0;
    r1_req_i = 1'b0;
    rst = 1'b1;
    free_at = 0;
    last_m = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic.
    pst[0] = 0; pst[1] = 0;
    for (int i = 0; i < 600; i++) begin
      mem_rdata_i = $urandom;
      for (int p = 0; p < 2; p++) begin
        if (pst[p] == 0) begin
          if ($urandom_range(0, 2) != 0) begin
            rand_port(p, 1'b1);
            pst[p] = 1;
          end else begin
            rand_port(p, 1'b0);
          end
        end else if (pst[p] == 2) begin
          if ($urandom_range(0, 3) == 0) rand_port(p, (p == 0) ? r0_req_i : r1_req_i);
          if ($urandom_range(0, 7) == 0) begin
            if (p == 0) r0_req_i = 1'b0; else r1_req_i = 1'b0;
          end
        end
      end
      cycle();
      for (int p = 0; p < 2; p++) begin
        if (g_seen[p]) pst[p] = 2;
        if (d_seen[p]) pst[p] = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
